mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 74HC153-style 4:1 data selector among

---
 rtl/mux_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner selection for one shared 4:1 data selector.
// Drives the select lines and the active-low strobe, and returns a registered Y sample to the owner.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic       Y_IN,
  output logic [3:0] GNT,
  output logic [1:0] S,
  output logic       E,
  output logic       Y_Q,
  output logic       Y_VLD,
  output logic       BUSY
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       s_q, s_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q_q, y_q_d;
  logic             y_vld_q, y_vld_d;

  logic [1:0] win;
  logic       found;
  logic [1:0] idx;

  // Circular priority scan starting at the pointer.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    e_d     = e_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    y_q_d   = Y_IN;
    y_vld_d = (state_q == GRANT);

    case (state_q)
      IDLE, GAP: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          s_d     = win;
          e_d     = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          e_d     = 1'b1;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        // Late requests are ignored here; they get their turn in the GAP cycle.
        if (!REQ[s_q] || cnt_q == HOLD_LAST) begin
          state_d = GAP;
          gnt_d   = 4'b0000;
          e_d     = 1'b1;
          busy_d  = 1'b0;
          ptr_d   = s_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        e_d     = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      s_q     <= 2'b00;
      e_q     <= 1'b1;
      busy_q  <= 1'b0;
      ptr_q   <= 2'b00;
      cnt_q   <= '0;
      y_q_q   <= 1'b0;
      y_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      y_q_q   <= y_q_d;
      y_vld_q <= y_vld_d;
    end
  end

  assign GNT   = gnt_q;
  assign S     = s_q;
  assign E     = e_q;
  assign BUSY  = busy_q;
  assign Y_Q   = y_q_q;
  assign Y_VLD = y_vld_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: grant order, hold limit, gap cycle, data path and async reset.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       y_in;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       e;
  logic       y_q;
  logic       y_vld;
  logic       busy;

  int tests_run;
  int tests_failed;

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .CLK  (clk),
    .RST  (rst),
    .REQ  (req),
    .Y_IN (y_in),
    .GNT  (gnt),
    .S    (s),
    .E    (e),
    .Y_Q  (y_q),
    .Y_VLD(y_vld),
    .BUSY (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] order [5];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst  = 1'b1;
    req  = 4'b0000;
    y_in = 1'b0;
    order[0] = 4'b0010;
    order[1] = 4'b0100;
    order[2] = 4'b1000;
    order[3] = 4'b0001;
    order[4] = 4'b0010;

    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_s", 32'(s), 32'h0);
    check("rst_e", 32'(e), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_yvld", 32'(y_vld), 32'h0);
    step();
    rst = 1'b0;

    // T2: single requester, PTR=0
    req = 4'b0100;
    step();
    check("t2_gnt_e1", 32'(gnt), 32'h4);
    check("t2_s_e1", 32'(s), 32'h2);
    check("t2_e_e1", 32'(e), 32'h0);
    check("t2_busy_e1", 32'(busy), 32'h1);
    step();
    step();
    check("t2_gnt_e3", 32'(gnt), 32'h4);
    req = 4'b0000;
    step();
    check("t2_gnt_rel", 32'(gnt), 32'h0);
    check("t2_e_rel", 32'(e), 32'h1);
    check("t2_s_keep", 32'(s), 32'h2);
    check("t2_yvld_rel", 32'(y_vld), 32'h1);
    step();
    check("t2_yvld_gap", 32'(y_vld), 32'h0);
    check("t2_e_idle", 32'(e), 32'h1);

    // T4 + T5: PTR=3, REQ=1001 -> 1000 first; Y path on index 3
    req = 4'b1001;
    step();
    check("t4_gnt_first", 32'(gnt), 32'h8);
    check("t4_s_first", 32'(s), 32'h3);
    y_in = 1'b1;
    step();
    check("t5_yq_1", 32'(y_q), 32'h1);
    check("t5_yvld_1", 32'(y_vld), 32'h1);
    y_in = 1'b0;
    step();
    check("t5_yq_2", 32'(y_q), 32'h0);
    check("t5_yvld_2", 32'(y_vld), 32'h1);
    y_in = 1'b1;
    step();
    check("t5_yq_3", 32'(y_q), 32'h1);
    check("t5_yvld_3", 32'(y_vld), 32'h1);
    y_in = 1'b0;
    repeat (4) step();
    check("t4_gnt_last_cycle", 32'(gnt), 32'h8);
    step();
    check("t4_gnt_forced_rel", 32'(gnt), 32'h0);
    check("t4_e_gap", 32'(e), 32'h1);
    check("t5_yvld_last", 32'(y_vld), 32'h1);
    step();
    check("t5_yvld_after_gap", 32'(y_vld), 32'h0);
    check("t4_gnt_second", 32'(gnt), 32'h1);
    check("t4_s_second", 32'(s), 32'h0);
    req = 4'b0000;
    step();
    check("t4_gnt_rel2", 32'(gnt), 32'h0);
    step();

    // T3: PTR=1, all requesting, 8-cycle holds with one gap cycle
    req = 4'b1111;
    step();
    for (int n = 0; n < 5; n++) begin
      check($sformatf("t3_gnt_start_%0d", n), 32'(gnt), 32'(order[n]));
      check($sformatf("t3_e_start_%0d", n), 32'(e), 32'h0);
      repeat (7) step();
      check($sformatf("t3_gnt_hold_%0d", n), 32'(gnt), 32'(order[n]));
      step();
      check($sformatf("t3_gnt_gap_%0d", n), 32'(gnt), 32'h0);
      check($sformatf("t3_e_gap_%0d", n), 32'(e), 32'h1);
      step();
    end
    check("t3_gnt_next", 32'(gnt), 32'h4);
    req = 4'b0000;
    step();
    step();
    check("t3_idle_busy", 32'(busy), 32'h0);

    // T6: owner 0010, REQ[0] rises mid-grant
    req = 4'b0010;
    step();
    check("t6_gnt_owner", 32'(gnt), 32'h2);
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t6_no_preempt_%0d", i), 32'(gnt), 32'h2);
    end
    req = 4'b0001;
    step();
    check("t6_gnt_gap", 32'(gnt), 32'h0);
    check("t6_e_gap", 32'(e), 32'h1);
    step();
    check("t6_gnt_next", 32'(gnt), 32'h1);
    check("t6_s_next", 32'(s), 32'h0);
    req = 4'b0000;
    step();
    step();

    // T1: async reset mid-grant of 0100 (PTR=1)
    req  = 4'b0100;
    y_in = 1'b1;
    step();
    check("t1_gnt_pre", 32'(gnt), 32'h4);
    step();
    check("t1_yvld_pre", 32'(y_vld), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_gnt", 32'(gnt), 32'h0);
    check("t1_e", 32'(e), 32'h1);
    check("t1_s", 32'(s), 32'h0);
    check("t1_yvld", 32'(y_vld), 32'h0);
    check("t1_yq", 32'(y_q), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    req  = 4'b0000;
    y_in = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("t1_gnt_after", 32'(gnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
